// File: rtl/module_key_capture.sv
// Keypad operand capture: turns debounced key presses into two decimal operands
// and requests one multiplication once both have been entered.
module module_key_capture #(
    parameter int         NDIGITS   = 2,
    parameter int         WIDTH     = 8,
    parameter logic [3:0] KEY_ENTER = 4'hA,
    parameter logic [3:0] KEY_CLEAR = 4'hB
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data_available_i,
    input  logic [3:0]       dato_i,
    output logic [WIDTH-1:0] op_a_o,
    output logic [WIDTH-1:0] op_b_o,
    output logic [1:0]       state_o,
    output logic             key_ack_o,
    output logic             start_o
);

    // Handshake: data_available_i is a level held for the whole key press and
    // dato_i is stable while it is high; only its rising edge is a key event.
    // key_ack_o pulses once for each event that was acted on; start_o pulses
    // once when operand B is closed. There is no back-pressure.

    localparam int              CW    = $clog2(NDIGITS + 1);
    localparam logic [CW-1:0]   N_MAX = CW'(NDIGITS);
    localparam logic [WIDTH+3:0] TEN  = (WIDTH + 4)'(10);

    typedef enum logic [1:0] {
        S_A    = 2'b00,
        S_B    = 2'b01,
        S_DONE = 2'b10,
        S_BAD  = 2'b11
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  op_a_q, op_a_d;
    logic [WIDTH-1:0]  op_b_q, op_b_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              ack_q, ack_d;
    logic              start_q, start_d;
    logic              dav_q;

    logic key_event;
    logic is_enter;
    logic is_clear;
    logic is_digit;
    logic has_room;

    function automatic logic [WIDTH-1:0] accumulate(input logic [WIDTH-1:0] op,
                                                    input logic [3:0]       digit);
        logic [WIDTH+3:0] wide;
        wide = {4'b0000, op} * TEN + {{WIDTH{1'b0}}, digit};
        return wide[WIDTH-1:0];
    endfunction

    assign key_event = data_available_i & ~dav_q;
    assign is_enter  = (dato_i == KEY_ENTER);
    assign is_clear  = (dato_i == KEY_CLEAR);
    assign is_digit  = (dato_i <= 4'd9) & ~is_enter & ~is_clear;
    assign has_room  = (cnt_q < N_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_A;
            op_a_q  <= '0;
            op_b_q  <= '0;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            start_q <= 1'b0;
            dav_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            start_q <= start_d;
            dav_q   <= data_available_i;
        end
    end

    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        start_d = 1'b0;

        if (key_event && is_clear) begin
            state_d = S_A;
            op_a_d  = '0;
            op_b_d  = '0;
            cnt_d   = '0;
            ack_d   = 1'b1;
        end else begin
            case (state_q)
                S_A: begin
                    if (key_event && is_enter) begin
                        state_d = S_B;
                        cnt_d   = '0;
                        ack_d   = 1'b1;
                    end else if (key_event && is_digit && has_room) begin
                        op_a_d = accumulate(op_a_q, dato_i);
                        cnt_d  = cnt_q + CW'(1);
                        ack_d  = 1'b1;
                    end
                end
                S_B: begin
                    if (key_event && is_enter) begin
                        state_d = S_DONE;
                        start_d = 1'b1;
                        ack_d   = 1'b1;
                    end else if (key_event && is_digit && has_room) begin
                        op_b_d = accumulate(op_b_q, dato_i);
                        cnt_d  = cnt_q + CW'(1);
                        ack_d  = 1'b1;
                    end
                end
                S_DONE: begin
                    // A new digit starts a fresh calculation; ENTER is ignored here.
                    if (key_event && is_digit) begin
                        state_d = S_A;
                        op_a_d  = {{(WIDTH-4){1'b0}}, dato_i};
                        op_b_d  = '0;
                        cnt_d   = CW'(1);
                        ack_d   = 1'b1;
                    end
                end
                default: begin
                    state_d = S_A;
                    op_a_d  = '0;
                    op_b_d  = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign op_a_o    = op_a_q;
    assign op_b_o    = op_b_q;
    assign state_o   = state_q;
    assign key_ack_o = ack_q;
    assign start_o   = start_q;

endmodule
